// File: rtl/risc_ice_v_reset_sequencer_if.sv
// PLL-lock input and staged reset outputs of the 50 MHz reset sequencer.
// The master side owns the lock/request inputs; the slave is the sequencer.
interface risc_ice_v_reset_sequencer_if;
    logic       pll_locked;
    logic       force_reset;
    logic       rst_memory;
    logic       rst_cpuunit;
    logic       rst_copro;
    logic       system_ready;
    logic [7:0] lock_lost_count;

    modport master (
        output pll_locked, force_reset,
        input  rst_memory, rst_cpuunit, rst_copro, system_ready, lock_lost_count
    );

    modport slave (
        input  pll_locked, force_reset,
        output rst_memory, rst_cpuunit, rst_copro, system_ready, lock_lost_count
    );
endinterface

// File: rtl/risc_ice_v_reset_sequencer.sv
// Synchronises PLL lock, waits for a stable interval, then releases memory,
// CPU-subunit and co-processor resets in order; any abort re-asserts all three.
module risc_ice_v_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16
) (
    input logic                          clock,
    input logic                          reset,
    risc_ice_v_reset_sequencer_if.slave  seqBus
);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        MEM_UP,
        CPU_UP,
        RUN
    } seqStateT;

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(STAGE_GAP - 1);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   lockedS;

    seqStateT    state, stateNext;
    logic [15:0] cnt, cntNext;
    logic        rstMem, rstMemNext;
    logic        rstCpu, rstCpuNext;
    logic        rstCopro, rstCoproNext;
    logic        ready, readyNext;
    logic [7:0]  lostCount, lostCountNext;
    logic        abort;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncChain <= '0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], seqBus.pll_locked};
        end
    end

    assign lockedS = syncChain[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            rstMem    <= 1'b1;
            rstCpu    <= 1'b1;
            rstCopro  <= 1'b1;
            ready     <= 1'b0;
            lostCount <= '0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            rstMem    <= rstMemNext;
            rstCpu    <= rstCpuNext;
            rstCopro  <= rstCoproNext;
            ready     <= readyNext;
            lostCount <= lostCountNext;
        end
    end

    // Abort wins over any stage advance evaluated in the same cycle.
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        rstMemNext    = rstMem;
        rstCpuNext    = rstCpu;
        rstCoproNext  = rstCopro;
        readyNext     = ready;
        lostCountNext = lostCount;
        abort         = (state != WAIT_LOCK) && (!lockedS || seqBus.force_reset);

        if (abort) begin
            stateNext    = WAIT_LOCK;
            cntNext      = '0;
            rstMemNext   = 1'b1;
            rstCpuNext   = 1'b1;
            rstCoproNext = 1'b1;
            readyNext    = 1'b0;
            if (!lockedS && (state inside {MEM_UP, CPU_UP, RUN})) begin
                lostCountNext = satInc(lostCount);
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cntNext      = '0;
                    rstMemNext   = 1'b1;
                    rstCpuNext   = 1'b1;
                    rstCoproNext = 1'b1;
                    readyNext    = 1'b0;
                    if (lockedS && !seqBus.force_reset) begin
                        stateNext = STABLE;
                    end
                end
                STABLE: begin
                    if (cnt == LOCK_LAST) begin
                        stateNext  = MEM_UP;
                        cntNext    = '0;
                        rstMemNext = 1'b0;
                    end else begin
                        cntNext = cnt + 16'd1;
                    end
                end
                MEM_UP: begin
                    if (cnt == GAP_LAST) begin
                        stateNext  = CPU_UP;
                        cntNext    = '0;
                        rstCpuNext = 1'b0;
                    end else begin
                        cntNext = cnt + 16'd1;
                    end
                end
                CPU_UP: begin
                    if (cnt == GAP_LAST) begin
                        stateNext    = RUN;
                        cntNext      = '0;
                        rstCoproNext = 1'b0;
                        readyNext    = 1'b1;
                    end else begin
                        cntNext = cnt + 16'd1;
                    end
                end
                RUN: begin
                    stateNext = RUN;
                end
                default: begin
                    stateNext = WAIT_LOCK;
                end
            endcase
        end
    end

    assign seqBus.rst_memory      = rstMem;
    assign seqBus.rst_cpuunit     = rstCpu;
    assign seqBus.rst_copro       = rstCopro;
    assign seqBus.system_ready    = ready;
    assign seqBus.lock_lost_count = lostCount;

endmodule

// File: doc/risc_ice_v_reset_sequencer.md
# risc_ice_v_reset_sequencer

Consumes the PLL `locked` indication and produces the ordered, synchronous reset releases for the 50 MHz domains. The block synchronises the asynchronous lock flag and requires it to stay stable for a programmable interval. It then releases memory, CPU-subunit and co-processor resets in sequence, and re-asserts all of them on lock loss or software request. It sits directly behind the PLL and runs on the PLL output clock.

## Interface
- `SYNC_STAGES`, default 2: flops in the `pll_locked` synchroniser chain; minimum 2.
- `LOCK_STABLE_CYCLES`, default 1024: cycles of continuous synchronised lock required before the first release; range 1..65536.
- `STAGE_GAP`, default 16: cycles between successive reset releases; range 1..65536.

- `clock` in 1: 50 MHz PLL output; sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clock`.
- `force_reset` in 1: synchronous software reset request, level or pulse.
- `rst_memory` out 1: active-high reset for the BRAM controller.
- `rst_cpuunit` out 1: active-high reset for the CPU subunits.
- `rst_copro` out 1: active-high reset for the co-processors.
- `system_ready` out 1: high only when all three resets are released.
- `lock_lost_count` out 8: saturating count of lock-loss events.

## Operation
- **Reset values.** `reset` high immediately sets `rst_*`=1, `system_ready`=0 and `lock_lost_count`=0. It also clears the synchroniser chain, clears the 16-bit cycle counter `cnt`, and sets the state to WAIT_LOCK.
- **Synchroniser.** `locked_s` is the last flop of the `SYNC_STAGES` chain. Only `locked_s` feeds the FSM.
- **Outputs.** All outputs are dedicated flops, updated on the same edge as the state. They are never combinational decodes.
- **FSM states:**
  - **WAIT_LOCK:** all resets 1 and `cnt`=0. Go to STABLE when `locked_s`=1 and `force_reset`=0.
  - **STABLE:** `cnt` increments each cycle. When `cnt`==`LOCK_STABLE_CYCLES`-1, go to MEM_UP, clear `cnt` and drive `rst_memory`=0.
  - **MEM_UP:** `cnt` increments. When `cnt`==`STAGE_GAP`-1, go to CPU_UP, clear `cnt` and drive `rst_cpuunit`=0.
  - **CPU_UP:** `cnt` increments. When `cnt`==`STAGE_GAP`-1, go to RUN and drive `rst_copro`=0 and `system_ready`=1.
  - **RUN:** hold until an abort occurs.
- **Abort.** In any state other than WAIT_LOCK, `locked_s`=0 or `force_reset`=1 sends the FSM to WAIT_LOCK on the next edge. On that edge all three resets assert together, `system_ready`=0 and `cnt`=0. Abort has priority over any stage advance on the same cycle.
- **Lock-loss count.** `lock_lost_count` increments by 1, saturating at 255, when `locked_s`=0 causes an abort from MEM_UP, CPU_UP or RUN. This applies even if `force_reset` is also high. Aborts from STABLE and aborts caused only by `force_reset` do not count.
- **Release order.** Releases are always in the order memory, CPU, co-processor. Assertion is always simultaneous.

## Timing
- **Release latency.** `pll_locked` rises before edge 1. With `SYNC_STAGES`=S, `locked_s` is high after edge S, and STABLE is entered at edge S+1.
  - `rst_memory` falls at edge S+1+`LOCK_STABLE_CYCLES`.
  - `rst_cpuunit` falls at edge S+1+`LOCK_STABLE_CYCLES`+`STAGE_GAP`.
  - `rst_copro` and `system_ready` change at edge S+1+`LOCK_STABLE_CYCLES`+2·`STAGE_GAP`.
  - Defaults give edges 1027, 1043 and 1059.
- **Lock-loss latency.** `pll_locked` falls before edge k. All resets assert at edge k+S, and `lock_lost_count` updates on that same edge.
- **force_reset latency.** `force_reset` high at edge k asserts all resets at edge k. While it is held, the FSM stays in WAIT_LOCK. After it drops, the full release sequence restarts.
- **Glitch filtering.** A `pll_locked` glitch shorter than one clock period may be missed or may cause a restart. It never produces a partial release.

## Test plan
- **Default release:** `SYNC_STAGES`=2, `LOCK_STABLE_CYCLES`=8, `STAGE_GAP`=4; `pll_locked` rises before edge 1. Required: `rst_memory` falls at edge 11, `rst_cpuunit` at edge 15, `rst_copro` and `system_ready` at edge 19; `lock_lost_count`=0.
- **Lock dropout in STABLE:** same parameters; `pll_locked` low for 1 cycle before edge 6. Required: FSM returns to WAIT_LOCK, no reset releases before edge 11+, `cnt` restarts from 0, `lock_lost_count` stays 0.
- **Lock loss in RUN:** after full release, drop `pll_locked` before edge 30. Required: all three resets 1 and `system_ready`=0 at edge 32; `lock_lost_count`=1; re-lock repeats the 8/4/4 sequence.
- **Lock loss in MEM_UP with simultaneous force_reset:** assert both in MEM_UP. Required: all resets assert together and `lock_lost_count` increments once. Then pulse `force_reset` alone in RUN. Required: resets assert at that edge and the count is unchanged.
- **Saturation:** 300 lock-loss cycles from RUN. Required: `lock_lost_count` holds at 255.
- **Async reset mid-sequence:** assert `reset` mid-MEM_UP, between clock edges. Required: `rst_memory`=1 and `lock_lost_count`=0 immediately, without a clock edge. After deassertion with lock held, the sequence completes at the expected edges relative to the deassertion.
